// File: rtl/hash_msg_framer_pkg.sv
// ---------------------------------------------------------------------------
// hash_framer_pkg
// Shared types and constants for the hash message framer: the framer FSM
// state encoding, byte and digest widths, and the digest the hash core
// produces for a zero-length message (used as a reference by benches).
// ---------------------------------------------------------------------------
package hash_framer_pkg;

    localparam int BYTE_W   = 8;
    localparam int DIGEST_W = 32;

    // Digest of the empty message as produced by the attached hash core.
    localparam logic [DIGEST_W-1:0] EMPTY_MSG_DIGEST = 32'h956F7883;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STREAM   = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_WAIT_DIG = 3'd3,
        ST_RESULT   = 3'd4
    } framer_state_t;

endpackage

// File: rtl/hash_msg_framer_if.sv
// ---------------------------------------------------------------------------
// hash_msg_framer_if
// Bundles every handshake/bus signal of the framer:
//   command   : cmd_valid, cmd_ready, cmd_len
//   byte input: in_valid, in_ready, in_data
//   core side : M_valid, C_in, M (to core), hash_ready, digest_in (from core)
//   result    : out_valid, out_ready, out_digest, out_err
// Modports:
//   slave  - the framer itself
//   master - the host / core environment driving the framer
// ---------------------------------------------------------------------------
interface hash_msg_framer_if #(
    parameter int LEN_W = 64
);
    import hash_framer_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [LEN_W-1:0]    cmd_len;

    logic                in_valid;
    logic                in_ready;
    logic [BYTE_W-1:0]   in_data;

    logic                M_valid;
    logic [LEN_W-1:0]    C_in;
    logic [BYTE_W-1:0]   M;
    logic                hash_ready;
    logic [DIGEST_W-1:0] digest_in;

    logic                out_valid;
    logic                out_ready;
    logic [DIGEST_W-1:0] out_digest;
    logic                out_err;

    modport slave (
        input  cmd_valid, cmd_len, in_valid, in_data, hash_ready, digest_in, out_ready,
        output cmd_ready, in_ready, M_valid, C_in, M, out_valid, out_digest, out_err
    );

    modport master (
        output cmd_valid, cmd_len, in_valid, in_data, hash_ready, digest_in, out_ready,
        input  cmd_ready, in_ready, M_valid, C_in, M, out_valid, out_digest, out_err
    );

endinterface

// File: rtl/hash_msg_framer_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Synchronous DEPTH x 8 FIFO with a registered read port.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (empties the FIFO)
//   push/wr_data- write one byte (ignored when full unless popping too)
//   pop         - load the head byte into rd_data and advance (ignored when empty)
//   rd_zero     - load 0 into rd_data without popping
//   rd_data     - registered read data, holds between pops
//   full/empty  - occupancy flags
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module byte_fifo
    import hash_framer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              pop,
    input  logic              rd_zero,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [BYTE_W-1:0] rd_data_q, rd_data_d;
    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = rd_data_q;

    always_comb begin
        do_pop    = pop && !empty;
        // A pop in the same cycle frees the slot, so push-while-full is safe then.
        do_push   = push && (!full || do_pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
            rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
        end else if (rd_zero) begin
            rd_data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is pure data: no reset needed, occupancy lives in the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/hash_msg_framer.sv
// ---------------------------------------------------------------------------
// hash_msg_framer
// Feeds a hash core from a host byte stream. The host issues a length
// command, then streams bytes under valid/ready; bytes are buffered in a
// byte_fifo and replayed to the core as M_valid/M strobes with C_in held at
// the message length. After the last strobe the framer waits SETTLE_CYC
// cycles (so a stale hash_ready from the previous message is never taken),
// then waits up to TIMEOUT_CYC cycles for hash_ready and returns the digest
// (or an error with a zero digest) on a valid/ready result port.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - hash_msg_framer_if.slave: command, byte input, core and
//                result interfaces
// SETTLE_CYC and TIMEOUT_CYC must be at least 1.
// ---------------------------------------------------------------------------
module hash_msg_framer
    import hash_framer_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int LEN_W       = 64,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    hash_msg_framer_if.slave bus
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST  = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] TIMEOUT_LAST = TMO_W'(TIMEOUT_CYC - 1);

    framer_state_t       state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [LEN_W-1:0]    sent_cnt_q, sent_cnt_d;
    logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic                out_valid_q, out_valid_d;
    logic [DIGEST_W-1:0] out_digest_q, out_digest_d;
    logic                out_err_q, out_err_d;

    logic                cmd_ready;
    logic                in_ready;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_zero;
    logic                fifo_full;
    logic                fifo_empty;
    logic [BYTE_W-1:0]   fifo_rd_data;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (bus.in_data),
        .pop     (fifo_pop),
        .rd_zero (fifo_zero),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The FIFO read register doubles as the M output register: it only
    // changes on a pop (or the zero-length strobe), so M holds between strobes.
    assign bus.M          = fifo_rd_data;
    assign bus.M_valid    = m_valid_q;
    assign bus.C_in       = len_q;
    assign bus.cmd_ready  = cmd_ready;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_digest = out_digest_q;
    assign bus.out_err    = out_err_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        acc_cnt_d    = acc_cnt_q;
        sent_cnt_d   = sent_cnt_q;
        settle_cnt_d = settle_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        m_valid_d    = 1'b0;
        out_valid_d  = out_valid_q;
        out_digest_d = out_digest_q;
        out_err_d    = out_err_q;
        cmd_ready    = (state_q == ST_IDLE);
        in_ready     = 1'b0;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        fifo_zero    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    len_d      = bus.cmd_len;
                    acc_cnt_d  = '0;
                    sent_cnt_d = '0;
                    state_d    = ST_STREAM;
                end
            end

            ST_STREAM: begin
                settle_cnt_d = '0;
                // acc_cnt never exceeds len, so the counters cannot wrap.
                in_ready  = !fifo_full && (acc_cnt_q < len_q);
                fifo_push = bus.in_valid && in_ready;
                if (fifo_push) begin
                    acc_cnt_d = acc_cnt_q + LEN_W'(1);
                end

                if (len_q == '0) begin
                    // Zero-length message: one strobe with M=0. M_valid was
                    // low on entry, so a high M_valid here is our own strobe.
                    if (m_valid_q) begin
                        state_d = ST_SETTLE;
                    end else begin
                        m_valid_d = 1'b1;
                        fifo_zero = 1'b1;
                    end
                end else if (sent_cnt_q == len_q) begin
                    // Final strobe is visible this cycle; settle starts next.
                    state_d = ST_SETTLE;
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    m_valid_d  = 1'b1;
                    sent_cnt_d = sent_cnt_q + LEN_W'(1);
                end
            end

            ST_SETTLE: begin
                tmo_cnt_d = '0;
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_WAIT_DIG;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end

            ST_WAIT_DIG: begin
                if (bus.hash_ready) begin
                    out_digest_d = bus.digest_in;
                    out_err_d    = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = ST_RESULT;
                end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    out_digest_d = '0;
                    out_err_d    = 1'b1;
                    out_valid_d  = 1'b1;
                    state_d      = ST_RESULT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            ST_RESULT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    len_d       = '0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            acc_cnt_q    <= '0;
            sent_cnt_q   <= '0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            m_valid_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_digest_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            acc_cnt_q    <= acc_cnt_d;
            sent_cnt_q   <= sent_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            m_valid_q    <= m_valid_d;
            out_valid_q  <= out_valid_d;
            out_digest_q <= out_digest_d;
            out_err_q    <= out_err_d;
        end
    end

endmodule

// File: tb/tb_hash_msg_framer.sv
// ---------------------------------------------------------------------------
// tb_hash_msg_framer
// Drives length commands and byte streams into hash_msg_framer, emulates the
// hash core (FNV-1a over the received bytes, fixed constant for the empty
// message, hash_ready a few cycles after the last byte), and compares each
// result with a digest computed directly from the message that was offered.
// ---------------------------------------------------------------------------
module tb_hash_msg_framer;
    import hash_framer_pkg::*;

    localparam int FIFO_DEPTH  = 16;
    localparam int LEN_W       = 64;
    localparam int SETTLE_CYC  = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int CORE_DLY    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hash_msg_framer_if #(.LEN_W(LEN_W)) bus ();

    hash_msg_framer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .LEN_W       (LEN_W),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
        return (h ^ {24'h0, b}) * 32'h0100_0193;
    endfunction

    // Offered message bytes; the first len of them form the message.
    logic [7:0] msg [$];

    function automatic logic [31:0] ref_digest(input longint len);
        logic [31:0] h;
        if (len == 0) return EMPTY_MSG_DIGEST;
        h = 32'h811C_9DC5;
        for (longint i = 0; i < len; i++) h = fnv_step(h, msg[i]);
        return h;
    endfunction

    // ---------------- core emulation and strobe monitor ----------------
    logic        stub_dead = 1'b0;
    bit          core_busy;
    longint      core_cnt;
    logic [31:0] core_h;
    int          core_dly;
    int          mv_cnt = 0;
    longint      mv_first_cyc = 0;
    longint      mv_last_cyc = 0;
    logic [7:0]  mv_last_m = 8'h0;
    logic [63:0] mv_last_cin = 64'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            core_busy      = 1'b0;
            core_dly       = 0;
            bus.hash_ready = 1'b0;
            bus.digest_in  = 32'h0;
        end else if (bus.M_valid) begin
            mv_cnt++;
            mv_last_cyc = cyc;
            mv_last_m   = bus.M;
            mv_last_cin = bus.C_in;
            if (!core_busy) begin
                core_busy      = 1'b1;
                core_cnt       = 0;
                core_h         = 32'h811C_9DC5;
                bus.hash_ready = 1'b0;
                mv_first_cyc   = cyc;
            end
            core_h = fnv_step(core_h, bus.M);
            core_cnt++;
            if (bus.C_in == 64'd0 || core_cnt == longint'(bus.C_in)) begin
                core_busy     = 1'b0;
                core_dly      = CORE_DLY;
                bus.digest_in = (bus.C_in == 64'd0) ? EMPTY_MSG_DIGEST : core_h;
            end
        end else if (core_dly > 0) begin
            core_dly--;
            if (core_dly == 0 && !stub_dead) bus.hash_ready = 1'b1;
        end
    end

    // ---------------- one complete transaction ----------------
    // Entered and left at #1 after a rising edge.
    task automatic run_msg(input longint len, input int pace, input int offer, input int hold,
                           output logic [31:0] dig, output logic err, output int accepted,
                           output int pulses, output longint tail, output longint first_acc);
        int  base;
        int  budget;
        bit  got;
        bit  stable;
        bit  busy_ok;
        base      = mv_cnt;
        accepted  = 0;
        got       = 1'b0;
        first_acc = -1;
        budget    = 100;
        while (!bus.cmd_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 64'(len);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("c_in_after_cmd", bus.C_in, 64'(len));
        budget = offer * pace * 2 + 400 + TIMEOUT_CYC;
        for (int c = 0; c < budget && !got; c++) begin
            if (bus.out_valid) begin
                got = 1'b1;
            end else begin
                if (accepted < offer && (c % pace) == 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = msg[accepted];
                    if (bus.in_ready) begin
                        if (accepted == 0) first_acc = cyc;
                        accepted++;
                    end
                end else begin
                    bus.in_valid = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
        check("out_valid_seen", 64'(got), 64'd1);
        tail    = cyc - mv_last_cyc;
        dig     = bus.out_digest;
        err     = bus.out_err;
        check("c_in_in_result", bus.C_in, 64'(len));
        stable  = 1'b1;
        busy_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.out_digest !== dig || bus.out_err !== err) stable = 1'b0;
            if (bus.cmd_ready) busy_ok = 1'b0;
        end
        if (hold > 0) begin
            check("result_stable", 64'(stable), 64'd1);
            check("cmd_ready_low_in_result", 64'(busy_ok), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_dropped", 64'(bus.out_valid), 64'd0);
        pulses = mv_cnt - base;
    endtask

    task automatic fill_seq(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'(i));
    endtask

    task automatic fill_rand(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
    endtask

    logic [31:0] dig, dig_fast, dig_slow;
    logic        err;
    int          acc, pulses;
    longint      tail, first_acc;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid",    64'(bus.M_valid),    64'd0);
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_c_in",       bus.C_in,            64'd0);
        check("rst_out_digest", 64'(bus.out_digest), 64'd0);
        check("rst_out_err",    64'(bus.out_err),    64'd0);
        check("rst_in_ready",   64'(bus.in_ready),   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty message.
        msg.delete();
        run_msg(0, 1, 0, 0, dig, err, acc, pulses, tail, first_acc);
        check("empty_digest", 64'(dig), 64'(EMPTY_MSG_DIGEST));
        check("empty_err", 64'(err), 64'd0);
        check("empty_pulses", 64'(pulses), 64'd1);
        check("empty_c_in", mv_last_cin, 64'd0);

        // One byte 0x41.
        msg.delete();
        msg.push_back(8'h41);
        run_msg(1, 1, 1, 0, dig, err, acc, pulses, tail, first_acc);
        check("one_digest", 64'(dig), 64'(ref_digest(1)));
        check("one_m", 64'(mv_last_m), 64'h41);
        check("one_c_in", mv_last_cin, 64'd1);
        check("one_pulses", 64'(pulses), 64'd1);
        check("settle_tail", 64'(tail),
              64'(((1 + SETTLE_CYC) > CORE_DLY ? (1 + SETTLE_CYC) : CORE_DLY) + 1));

        // Empty message after a non-zero byte: M must be forced to 0.
        run_msg(0, 1, 0, 0, dig, err, acc, pulses, tail, first_acc);
        check("empty2_m", 64'(mv_last_m), 64'd0);
        check("empty2_digest", 64'(dig), 64'(EMPTY_MSG_DIGEST));

        // Pacing independence, plus latency and throughput on the fed run.
        fill_seq(156);
        run_msg(156, 1, 156, 0, dig_fast, err, acc, pulses, tail, first_acc);
        check("fast_digest", 64'(dig_fast), 64'(ref_digest(156)));
        check("fast_pulses", 64'(pulses), 64'd156);
        check("first_byte_latency", 64'(mv_first_cyc - first_acc), 64'd2);
        check("one_byte_per_cycle", 64'(mv_last_cyc - mv_first_cyc), 64'd155);
        run_msg(156, 3, 156, 0, dig_slow, err, acc, pulses, tail, first_acc);
        check("slow_digest", 64'(dig_slow), 64'(ref_digest(156)));
        check("slow_pulses", 64'(pulses), 64'd156);
        check("pace_independent", 64'(dig_slow), 64'(dig_fast));

        // Overrun guard.
        fill_rand(300);
        run_msg(255, 1, 300, 0, dig, err, acc, pulses, tail, first_acc);
        check("overrun_accepted", 64'(acc), 64'd255);
        check("overrun_pulses", 64'(pulses), 64'd255);
        check("overrun_digest", 64'(dig), 64'(ref_digest(255)));

        // Result backpressure.
        fill_rand(20);
        run_msg(20, 2, 20, 10, dig, err, acc, pulses, tail, first_acc);
        check("hold_digest", 64'(dig), 64'(ref_digest(20)));

        // Randomized messages: length, pacing, extra bytes and result hold.
        for (int t = 0; t < 6; t++) begin
            int len, pace, extra, hold;
            len   = $urandom_range(0, 40);
            pace  = $urandom_range(1, 4);
            extra = $urandom_range(0, 3);
            hold  = $urandom_range(0, 3);
            fill_rand(len + extra);
            run_msg(len, pace, len + extra, hold, dig, err, acc, pulses, tail, first_acc);
            check($sformatf("rand%0d_digest", t), 64'(dig), 64'(ref_digest(len)));
            check($sformatf("rand%0d_err", t), 64'(err), 64'd0);
            check($sformatf("rand%0d_accepted", t), 64'(acc), 64'(len));
            check($sformatf("rand%0d_pulses", t), 64'(pulses), 64'(len == 0 ? 1 : len));
        end

        // Long message.
        fill_rand(5073);
        run_msg(5073, 1, 5073, 0, dig, err, acc, pulses, tail, first_acc);
        check("long_err", 64'(err), 64'd0);
        check("long_digest", 64'(dig), 64'(ref_digest(5073)));
        check("long_pulses", 64'(pulses), 64'd5073);

        // Timeout: the core never raises hash_ready.
        stub_dead = 1'b1;
        fill_rand(5);
        run_msg(5, 1, 5, 0, dig, err, acc, pulses, tail, first_acc);
        check("timeout_err", 64'(err), 64'd1);
        check("timeout_digest", 64'(dig), 64'd0);
        check("timeout_latency", 64'(tail), 64'(1 + SETTLE_CYC + TIMEOUT_CYC));
        stub_dead = 1'b0;

        // Reset in the middle of a message.
        fill_seq(156);
        check("pre_reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 64'd156;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        acc = 0;
        for (int c = 0; c < 400 && acc < 50; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = msg[acc];
            if (bus.in_ready) acc++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("mid_accepted", 64'(acc), 64'd50);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", 64'(bus.M_valid), 64'd0);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_c_in", bus.C_in, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_msg(156, 1, 156, 0, dig, err, acc, pulses, tail, first_acc);
        check("post_reset_digest", 64'(dig), 64'(dig_fast));
        check("post_reset_pulses", 64'(pulses), 64'd156);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/hash_msg_framer.md
Name: hash_msg_framer

Overview:
Upstream feeder for fullHashDES. Accepts a length command and a backpressured byte stream from the host side, and buffers the bytes in a small FIFO. Drives the core's M_valid/C_in/M interface, then captures digest_out once hash_ready asserts and returns it through a valid/ready result port. It removes the need for the host to pace bytes or know core timing.

Parameters:
FIFO_DEPTH, 16, byte FIFO depth; power of two, minimum 2
LEN_W, 64, width of message length (matches C_in)
SETTLE_CYC, 2, cycles after the final M_valid before hash_ready is trusted
TIMEOUT_CYC, 64, maximum cycles spent waiting for hash_ready before flagging an error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  length command valid
cmd_ready  out  1  high only in IDLE
cmd_len  in  LEN_W  message length in bytes (0 allowed)
in_valid  in  1  message byte valid
in_ready  out  1  byte accepted when in_valid and in_ready are both high
in_data  in  8  message byte
M_valid  out  1  byte/start strobe to core
C_in  out  LEN_W  message length to core
M  out  8  message byte to core
hash_ready  in  1  core digest-valid level
digest_in  in  32  core digest_out
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_digest  out  32  captured digest
out_err  out  1  timeout occurred; out_digest is 0

Behaviour:
- Reset (asynchronous, active-low) forces all outputs and state to 0, state=IDLE, and the FIFO empty. A reset mid-message abandons it; no partial result is produced.
- States: IDLE, STREAM, SETTLE, WAIT_DIG, RESULT.
- IDLE: cmd_ready=1. On cmd_valid:
  - register len=cmd_len and drive C_in=len from the next cycle;
  - clear acc_cnt and sent_cnt;
  - go to STREAM.
- C_in holds its value from command accept until the exit from RESULT.
- STREAM, byte input:
  - in_ready = !fifo_full && (acc_cnt < len);
  - each accepted byte increments acc_cnt, so bytes beyond len are never accepted.
- STREAM, core output:
  - when the FIFO is non-empty and sent_cnt < len: pop, M=byte, M_valid=1 for that cycle, sent_cnt++;
  - gaps (M_valid=0 cycles) are legal and occur whenever the FIFO is empty;
  - M and M_valid are registered, and M holds its last value when M_valid=0.
- len=0: STREAM issues exactly one M_valid pulse with M=0 and C_in=0.
- STREAM -> SETTLE in the cycle after the final M_valid, i.e. once sent_cnt==len, or after the single pulse when len=0.
- SETTLE: counts SETTLE_CYC cycles with M_valid=0 and ignores hash_ready, so a stale level from the previous message is not captured. Then go to WAIT_DIG.
- WAIT_DIG:
  - on the first cycle with hash_ready=1: out_digest<=digest_in, out_err<=0, go to RESULT;
  - if TIMEOUT_CYC cycles elapse first: out_digest<=0, out_err<=1, go to RESULT.
- RESULT: out_valid=1 with out_digest and out_err stable until out_ready is sampled high. Then out_valid<=0 and state=IDLE; the next command can be accepted one cycle later.
- Throughput: with the FIFO kept fed, one byte per cycle. Latency from the first accepted byte to the first M_valid is 2 cycles (FIFO write, then registered pop).
- A simultaneous FIFO push and pop is allowed in the full and empty states. Push when full is impossible because in_ready is low.
- Counters are LEN_W bits and do not wrap; len=2^LEN_W-1 is legal.
- The timeout counter is $clog2(TIMEOUT_CYC+1) bits; the settle counter is $clog2(SETTLE_CYC+1) bits.

Decomposition:
- Package hash_framer_pkg holds:
  - the state enum typedef (framer_state_t);
  - localparam BYTE_W=8;
  - localparam DIGEST_W=32;
  - the expected empty-message digest constant 32'h956F7883 for benches.
- One sub-module, byte_fifo: synchronous FIFO of FIFO_DEPTH x 8 with the same clk/rst_n, push/pop, full/empty, and a registered read. The FSM, counters and result register stay in hash_msg_framer.

Test Plan:
- Empty message: cmd_len=0 with the real fullHashDES attached -> exactly one M_valid pulse with C_in=0, then out_valid with out_digest=32'h956F7883 and out_err=0.
- One byte: cmd_len=1, in_data=8'h41 -> one M_valid with M=8'h41 and C_in=1; out_digest equals the digest the core produces for a direct single-byte 8'h41 feed.
- Pacing independence: 156 bytes 0..155 sent back-to-back, then the same 156 bytes with in_valid high only every 3rd cycle -> identical out_digest; M_valid count = 156 in both runs.
- Overrun guard: cmd_len=255 while the host offers 300 bytes -> in_ready drops after 255 accepted bytes and exactly 255 M_valid pulses occur. A 5073-byte message completes with out_err=0.
- Result backpressure and timeout: hold out_ready=0 for 10 cycles -> out_valid and out_digest stable and cmd_ready=0 throughout. Then, with hash_ready stubbed at 0, a new command -> out_err=1 and out_digest=0 exactly TIMEOUT_CYC cycles after WAIT_DIG entry.
- Reset mid-message: assert rst_n=0 after 50 of 156 bytes -> M_valid, out_valid and C_in are 0 immediately. After release, a fresh 156-byte message gives the same digest as the pacing test.
